// File: rtl/mini_mem_bist.sv
// Memory BIST initiator: writes a pattern to every RAM address, reads it back and reports mismatches.
// Optional MEM_BIST_ERR_INJECT_EN adds i_inj_en/i_inj_addr to corrupt bit 0 of one written word.
module mini_mem_bist #(
    parameter int         AW     = 8,
    parameter int         RD_LAT = 1,
    parameter logic [7:0] SEED   = 8'hA5
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          i_start,
    input  logic [1:0]    i_mode,
`ifdef MEM_BIST_ERR_INJECT_EN
    input  logic          i_inj_en,
    input  logic [AW-1:0] i_inj_addr,
`endif
    output logic [AW-1:0] o_addr,
    output logic [7:0]    o_data_wr,
    output logic          o_wr,
    output logic          o_rd,
    input  logic [7:0]    i_data_rd,
    output logic          o_busy,
    output logic          o_done,
    output logic          o_pass,
    output logic [15:0]   o_err_cnt,
    output logic [AW-1:0] o_fail_addr
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_WRITE,
        S_READ,
        S_DRAIN,
        S_DONE
    } state_t;

    localparam logic [AW-1:0] LAST_ADDR = {AW{1'b1}};

    state_t        state_q;
    logic [AW-1:0] cnt_q;
    logic [2:0]    drain_q;
    logic [7:0]    lfsr_q;
    logic [7:0]    lfsr_d;
    logic [1:0]    mode_q;

    logic [AW-1:0] addr_q;
    logic [7:0]    data_wr_q;
    logic          wr_q;
    logic          rd_q;
    logic          busy_q;
    logic          done_q;
    logic          pass_q;
    logic [15:0]   err_cnt_q;
    logic [15:0]   err_cnt_d;
    logic [AW-1:0] fail_addr_q;
    logic [AW-1:0] fail_addr_d;

    // Stage 0 is loaded alongside o_rd; stage RD_LAT lines up with i_data_rd.
    logic          exp_vld_q;
    logic [7:0]    exp_data_q;
    logic [AW-1:0] exp_addr_q;
    logic [RD_LAT:1] pipe_vld_q;
    logic [7:0]    pipe_data_q [1:RD_LAT];
    logic [AW-1:0] pipe_addr_q [1:RD_LAT];

    logic [7:0]    pat_cur;
    logic [7:0]    inj_mask;
    logic          mismatch;

    function automatic logic [7:0] pattern(input logic [1:0] m, input logic [AW-1:0] a,
                                           input logic [7:0] l);
        logic [7:0] p;
        case (m)
            2'd0:    p = 8'(a);
            2'd1:    p = ~8'(a);
            2'd2:    p = l;
            default: p = a[0] ? 8'hAA : 8'h55;
        endcase
        return p;
    endfunction

    assign pat_cur = pattern(mode_q, cnt_q, lfsr_q);
    assign lfsr_d  = {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};

`ifdef MEM_BIST_ERR_INJECT_EN
    assign inj_mask = (i_inj_en && (cnt_q == i_inj_addr)) ? 8'h01 : 8'h00;
`else
    assign inj_mask = 8'h00;
`endif

    always_comb begin
        mismatch    = pipe_vld_q[RD_LAT] && (i_data_rd != pipe_data_q[RD_LAT]);
        err_cnt_d   = err_cnt_q;
        fail_addr_d = fail_addr_q;
        if (mismatch && (err_cnt_q != 16'hFFFF)) begin
            err_cnt_d = err_cnt_q + 16'd1;
        end
        if (mismatch && (err_cnt_q == 16'd0)) begin
            fail_addr_d = pipe_addr_q[RD_LAT];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            drain_q     <= '0;
            lfsr_q      <= SEED;
            mode_q      <= '0;
            addr_q      <= '0;
            data_wr_q   <= '0;
            wr_q        <= 1'b0;
            rd_q        <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            pass_q      <= 1'b0;
            err_cnt_q   <= '0;
            fail_addr_q <= '0;
            exp_vld_q   <= 1'b0;
            exp_data_q  <= '0;
            exp_addr_q  <= '0;
        end else begin
            wr_q        <= 1'b0;
            rd_q        <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            exp_vld_q   <= 1'b0;
            err_cnt_q   <= err_cnt_d;
            fail_addr_q <= fail_addr_d;
            case (state_q)
                S_IDLE: begin
                    if (i_start) begin
                        mode_q      <= i_mode;
                        err_cnt_q   <= '0;
                        fail_addr_q <= '0;
                        pass_q      <= 1'b0;
                        cnt_q       <= '0;
                        lfsr_q      <= SEED;
                        state_q     <= S_WRITE;
                    end
                end
                S_WRITE: begin
                    wr_q      <= 1'b1;
                    busy_q    <= 1'b1;
                    addr_q    <= cnt_q;
                    data_wr_q <= pat_cur ^ inj_mask;
                    cnt_q     <= cnt_q + AW'(1);
                    lfsr_q    <= lfsr_d;
                    if (cnt_q == LAST_ADDR) begin
                        cnt_q   <= '0;
                        lfsr_q  <= SEED;
                        state_q <= S_READ;
                    end
                end
                S_READ: begin
                    rd_q       <= 1'b1;
                    busy_q     <= 1'b1;
                    addr_q     <= cnt_q;
                    exp_vld_q  <= 1'b1;
                    exp_data_q <= pat_cur;
                    exp_addr_q <= cnt_q;
                    cnt_q      <= cnt_q + AW'(1);
                    lfsr_q     <= lfsr_d;
                    if (cnt_q == LAST_ADDR) begin
                        cnt_q   <= '0;
                        drain_q <= '0;
                        state_q <= S_DRAIN;
                    end
                end
                S_DRAIN: begin
                    // The final edge here also retires the last compare, so pass uses err_cnt_d.
                    if (drain_q == 3'(RD_LAT)) begin
                        done_q  <= 1'b1;
                        pass_q  <= (err_cnt_d == 16'd0);
                        state_q <= S_DONE;
                    end else begin
                        busy_q  <= 1'b1;
                        drain_q <= drain_q + 3'd1;
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pipe_vld_q <= '0;
            for (int i = 1; i <= RD_LAT; i++) begin
                pipe_data_q[i] <= '0;
                pipe_addr_q[i] <= '0;
            end
        end else begin
            pipe_vld_q[1]  <= exp_vld_q;
            pipe_data_q[1] <= exp_data_q;
            pipe_addr_q[1] <= exp_addr_q;
            for (int i = 2; i <= RD_LAT; i++) begin
                pipe_vld_q[i]  <= pipe_vld_q[i-1];
                pipe_data_q[i] <= pipe_data_q[i-1];
                pipe_addr_q[i] <= pipe_addr_q[i-1];
            end
        end
    end

    assign o_addr      = addr_q;
    assign o_data_wr   = data_wr_q;
    assign o_wr        = wr_q;
    assign o_rd        = rd_q;
    assign o_busy      = busy_q;
    assign o_done      = done_q;
    assign o_pass      = pass_q;
    assign o_err_cnt   = err_cnt_q;
    assign o_fail_addr = fail_addr_q;

endmodule

// File: tb/tb_mini_mem_bist.sv
// Self-checking bench for mini_mem_bist with a behavioural RAM (read latency 1) and fault modes.
// Expected writes and per-run results are queued at start and popped as the DUT produces them.
module tb_mini_mem_bist;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        i_start = 1'b0;
    logic [1:0]  i_mode = 2'd0;
    logic [7:0]  o_addr;
    logic [7:0]  o_data_wr;
    logic        o_wr;
    logic        o_rd;
    logic [7:0]  i_data_rd;
    logic        o_busy;
    logic        o_done;
    logic        o_pass;
    logic [15:0] o_err_cnt;
    logic [7:0]  o_fail_addr;
`ifdef MEM_BIST_ERR_INJECT_EN
    logic        inj_en = 1'b0;
    logic [7:0]  inj_addr = 8'h00;
`endif

    mini_mem_bist #(.AW(8), .RD_LAT(1), .SEED(8'hA5)) dut (
        .clk        (clk),
        .rst        (rst),
        .i_start    (i_start),
        .i_mode     (i_mode),
`ifdef MEM_BIST_ERR_INJECT_EN
        .i_inj_en   (inj_en),
        .i_inj_addr (inj_addr),
`endif
        .o_addr     (o_addr),
        .o_data_wr  (o_data_wr),
        .o_wr       (o_wr),
        .o_rd       (o_rd),
        .i_data_rd  (i_data_rd),
        .o_busy     (o_busy),
        .o_done     (o_done),
        .o_pass     (o_pass),
        .o_err_cnt  (o_err_cnt),
        .o_fail_addr(o_fail_addr)
    );

    always #5 clk = ~clk;

    // RAM model; fault 1 flips bit 7 when reading 0x3C, fault 2 reads all zeros.
    logic [7:0] mem [0:255];
    int         fault = 0;
    always @(posedge clk) begin
        if (o_wr) mem[o_addr] <= o_data_wr;
        if (o_rd) begin
            if (fault == 2)                          i_data_rd <= 8'h00;
            else if (fault == 1 && o_addr == 8'h3C)  i_data_rd <= mem[o_addr] ^ 8'h80;
            else                                     i_data_rd <= mem[o_addr];
        end
    end

    int edge_cnt = 0;
    always @(posedge clk) edge_cnt <= edge_cnt + 1;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    typedef struct {
        logic        pass;
        logic [15:0] err;
        logic [7:0]  fail;
        int          cyc;
    } res_t;

    logic [15:0] wr_exp_q [$];
    res_t        res_q [$];
    int          wr_seen = 0;
    int          rd_seen = 0;
    logic [7:0]  last_wr10 = 8'h00;

    always @(negedge clk) begin
        if (!rst) begin
            check_eq("wr_rd_exclusive", 64'(o_wr & o_rd), 64'd0);
            if (o_wr) begin
                wr_seen++;
                if (o_addr == 8'h10) last_wr10 = o_data_wr;
                check_eq("busy_during_write", 64'(o_busy), 64'd1);
                if (wr_exp_q.size() == 0) begin
                    check_eq("wr_unexpected", 64'(wr_exp_q.size()), 64'd1);
                end else begin
                    check_eq("wr_addr_data", {48'd0, o_addr, o_data_wr}, 64'(wr_exp_q.pop_front()));
                end
            end
            if (o_rd) rd_seen++;
        end
    end

    function automatic logic [7:0] tb_pat(input int mode, input int a, input logic [7:0] l);
        logic [7:0] av;
        av = 8'(a);
        case (mode)
            0:       return av;
            1:       return ~av;
            2:       return l;
            default: return (a % 2 == 1) ? 8'hAA : 8'h55;
        endcase
    endfunction

    // Queue the expected write stream and, optionally, the expected result of the run.
    task automatic build_expect(input int mode, input int flt, input bit push_res);
        logic [7:0]  l;
        logic [7:0]  p;
        logic [7:0]  w;
        logic [7:0]  r;
        logic [15:0] err;
        logic [7:0]  fail;
        res_t        e;
        l = 8'hA5; err = 0; fail = 0;
        for (int a = 0; a < 256; a++) begin
            p = tb_pat(mode, a, l);
            w = p;
`ifdef MEM_BIST_ERR_INJECT_EN
            if (inj_en && 8'(a) == inj_addr) w = w ^ 8'h01;
`endif
            wr_exp_q.push_back({8'(a), w});
            if (flt == 2)                    r = 8'h00;
            else if (flt == 1 && a == 8'h3C) r = w ^ 8'h80;
            else                             r = w;
            if (r != p) begin
                if (err == 0) fail = 8'(a);
                err++;
            end
            l = {l[6:0], l[7] ^ l[5] ^ l[4] ^ l[3]};
        end
        e.pass = (err == 0); e.err = err; e.fail = fail; e.cyc = 514;
        if (push_res) res_q.push_back(e);
    endtask

    task automatic run_test(input string name, input int mode, input int flt, input bit poke_busy);
        int   start_edge;
        int   guard;
        int   extra;
        res_t e;
        fault = flt;
        build_expect(mode, flt, 1'b1);
        @(negedge clk);
        i_mode = 2'(mode); i_start = 1'b1;
        start_edge = edge_cnt + 1;
        wr_seen = 0; rd_seen = 0;
        @(negedge clk);
        i_start = 1'b0;
        guard = 0;
        while (!o_done && guard < 2000) begin
            if (poke_busy && (guard == 100 || guard == 400)) begin
                i_start = 1'b1; i_mode = ~2'(mode);
            end else begin
                i_start = 1'b0; i_mode = 2'(mode);
            end
            @(negedge clk);
            guard++;
        end
        i_start = 1'b0; i_mode = 2'(mode);
        if (!o_done) begin
            check_eq({name, "_done_timeout"}, 64'(o_done), 64'd1);
            wr_exp_q.delete(); res_q.delete();
            return;
        end
        e = res_q.pop_front();
        check_eq({name, "_done_cycle"}, 64'(edge_cnt - start_edge), 64'(e.cyc));
        check_eq({name, "_pass"}, 64'(o_pass), 64'(e.pass));
        check_eq({name, "_err_cnt"}, 64'(o_err_cnt), 64'(e.err));
        check_eq({name, "_fail_addr"}, 64'(o_fail_addr), 64'(e.fail));
        check_eq({name, "_busy_at_done"}, 64'(o_busy), 64'd0);
        check_eq({name, "_writes"}, 64'(wr_seen), 64'd256);
        check_eq({name, "_reads"}, 64'(rd_seen), 64'd256);
        check_eq({name, "_wr_queue_empty"}, 64'(wr_exp_q.size()), 64'd0);
        $display("run %s mode=%0d: done_cycle=%0d pass=%0d err_cnt=%0d fail_addr=%02h",
                 name, mode, edge_cnt - start_edge, o_pass, o_err_cnt, o_fail_addr);
        // Start pulse during the DONE cycle must be ignored.
        i_start = 1'b1;
        @(negedge clk);
        i_start = 1'b0;
        check_eq({name, "_done_one_cycle"}, 64'(o_done), 64'd0);
        extra = 0;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            if (o_busy || o_wr || o_rd || o_done) extra++;
        end
        check_eq({name, "_start_in_done_ignored"}, 64'(extra), 64'd0);
        check_eq({name, "_pass_held"}, 64'(o_pass), 64'(e.pass));
        check_eq({name, "_err_held"}, 64'(o_err_cnt), 64'(e.err));
    endtask

    initial begin
        int guard;
        int dones;

        // Reset and idle behaviour
        rst = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            check_eq("idle_outputs_zero",
                     {19'd0, o_addr, o_data_wr, o_wr, o_rd, o_busy, o_done, o_pass,
                      o_err_cnt, o_fail_addr}, 64'd0);
        end
        $display("reset: outputs idle for 10 cycles");

        run_test("mode0_ideal", 0, 0, 1'b0);
        run_test("mode2_bit7_3C", 2, 1, 1'b0);
        run_test("mode3_stuck0", 3, 2, 1'b0);
        run_test("mode3_stuck0_poke", 3, 2, 1'b1);

        // Reset during READ at 0x80
        fault = 0;
        build_expect(0, 0, 1'b0);
        @(negedge clk);
        i_mode = 2'd0; i_start = 1'b1;
        @(negedge clk);
        i_start = 1'b0;
        guard = 0;
        while (!(o_rd && o_addr == 8'h80) && guard < 1000) begin
            @(negedge clk);
            guard++;
        end
        check_eq("rst_reached_read_80", {62'd0, o_rd, (o_addr == 8'h80)}, 64'd3);
        rst = 1'b1;
        @(negedge clk);
        check_eq("rst_mid_strobes", {62'd0, o_wr, o_rd}, 64'd0);
        check_eq("rst_mid_busy_done", {62'd0, o_busy, o_done}, 64'd0);
        check_eq("rst_mid_err_cnt", 64'(o_err_cnt), 64'd0);
        check_eq("rst_mid_addr", 64'(o_addr), 64'd0);
        rst = 1'b0;
        wr_exp_q.delete();
        dones = 0;
        for (int k = 0; k < 600; k++) begin
            @(negedge clk);
            if (o_done || o_busy) dones++;
        end
        check_eq("rst_mid_no_done", 64'(dones), 64'd0);
        $display("reset mid-test: strobes=%0d%0d err_cnt=%0d later_activity=%0d",
                 o_wr, o_rd, o_err_cnt, dones);

`ifdef MEM_BIST_ERR_INJECT_EN
        inj_en = 1'b1; inj_addr = 8'h10;
        run_test("mode1_inject", 1, 0, 1'b0);
        check_eq("inject_wr_data_10", 64'(last_wr10), 64'hEE);
        check_eq("inject_err_cnt", 64'(o_err_cnt), 64'd1);
        check_eq("inject_fail_addr", 64'(o_fail_addr), 64'h10);
        inj_en = 1'b0;
`else
        run_test("mode1_noinject", 1, 0, 1'b0);
        check_eq("mode1_wr_data_10", 64'(last_wr10), 64'hEF);
        check_eq("mode1_pass", 64'(o_pass), 64'd1);
`endif

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
